// File: rtl/data_mem_lsu.sv
// data_mem_lsu: byte-addressed single-port data RAM with RISC-V load/store lanes.
// Ports: clk, rst (async, active-high); req/we/funct3/addr/wdata request in;
//        ready, rsp_valid, rdata (extended load data), err response out.
// Macro DMEM_MISALIGN_SPLIT_EN: when defined, misaligned H/W accesses execute
//   (word-crossing ones take a second beat in SPLIT2); otherwise they return err.
`timescale 1ns/1ps
module data_mem_lsu #(
    parameter int    ADDR_W    = 10,
    parameter string INIT_FILE = "datamem_init.txt"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              rsp_valid,
    output logic [31:0]       rdata,
    output logic              err
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {
        IDLE   = 1'b0,
        SPLIT2 = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [31:0] mem [DEPTH];

    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic             is_h, is_w;
    logic             illegal, bad, split;
    logic [3:0]       be;
    logic [7:0]       sh_mask;
    logic [63:0]      sh_data;
    logic             accept, wr_lo, wr_hi;
    logic [IDX_W-1:0] rd_idx;

    logic [31:0]      rd_q, lo_q;
    logic             rsp_valid_q, err_q, ld_q, split_q, uns_q, hi_we_q;
    logic [1:0]       off_q, size_q;
    logic [IDX_W-1:0] hi_idx_q;
    logic [3:0]       hi_mask_q;
    logic [31:0]      hi_data_q;

    logic [63:0]      src;
    logic [31:0]      shr, ext;

    // Request decode
    assign off     = addr[1:0];
    assign idx     = addr[ADDR_W-1:2];
    assign is_h    = funct3[1:0] == 2'b01;
    assign is_w    = funct3[1:0] == 2'b10;
    assign illegal = (funct3[1:0] == 2'b11) || (funct3 == 3'b110)
                     || (we && funct3[2]);

`ifdef DMEM_MISALIGN_SPLIT_EN
    assign bad   = illegal;
    assign split = !illegal
                   && ((is_h && off == 2'd3) || (is_w && off != 2'd0));
`else
    assign bad   = illegal || (is_h && off[0]) || (is_w && off != 2'd0);
    assign split = 1'b0;
`endif

    always_comb begin
        be = 4'b0001;
        unique case (1'b1)
            is_w:    be = 4'b1111;
            is_h:    be = 4'b0011;
            default: be = 4'b0001;
        endcase
    end

    // Upper half of the 8-lane window belongs to the next word (second beat)
    assign sh_mask = {4'b0000, be} << off;
    assign sh_data = {32'h0, wdata} << {off, 3'b000};

    assign accept = req && ready && !rst;
    assign wr_lo  = accept && we && !bad;
    assign wr_hi  = (state_q == SPLIT2) && hi_we_q;
    assign rd_idx = (state_q == SPLIT2) ? hi_idx_q : idx;

    // FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (req && split && !rst) state_d = SPLIT2;
            end
            SPLIT2:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM: no reset, contents survive rst
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_lo && sh_mask[b])
                mem[idx][8*b +: 8] <= sh_data[8*b +: 8];
            if (wr_hi && hi_mask_q[b])
                mem[hi_idx_q][8*b +: 8] <= hi_data_q[8*b +: 8];
        end
        rd_q <= mem[rd_idx];
        // lo_q keeps the first-beat word once the second word arrives
        lo_q <= rd_q;
    end

    // Response / second-beat bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            ld_q        <= 1'b0;
            split_q     <= 1'b0;
            uns_q       <= 1'b0;
            hi_we_q     <= 1'b0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            hi_idx_q    <= '0;
            hi_mask_q   <= 4'h0;
            hi_data_q   <= 32'h0;
        end else begin
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            if (state_q == SPLIT2) begin
                rsp_valid_q <= 1'b1;
            end else if (accept) begin
                rsp_valid_q <= !split;
                err_q       <= bad;
                ld_q        <= !we && !bad;
                split_q     <= split;
                uns_q       <= funct3[2];
                hi_we_q     <= we && split;
                off_q       <= off;
                size_q      <= funct3[1:0];
                hi_idx_q    <= idx + 1'b1;
                hi_mask_q   <= sh_mask[7:4];
                hi_data_q   <= sh_data[63:32];
            end
        end
    end

    // Load alignment and extension
    always_comb begin
        src = split_q ? {rd_q, lo_q} : {32'h0, rd_q};
        shr = 32'(src >> {off_q, 3'b000});
        ext = shr;
        unique case (1'b1)
            size_q == 2'b00:
                ext = uns_q ? {24'h0, shr[7:0]} : {{24{shr[7]}}, shr[7:0]};
            size_q == 2'b01:
                ext = uns_q ? {16'h0, shr[15:0]} : {{16{shr[15]}}, shr[15:0]};
            default: ext = shr;
        endcase
        rdata = (rsp_valid_q && ld_q) ? ext : 32'h0;
    end

    assign rsp_valid = rsp_valid_q;
    assign err       = err_q;

endmodule
